// File: rtl/cs_loader.sv
`timescale 1ns/1ps
// cs_loader: startup FSM that copies the microcode EPROM into the control-store RAM.
// Define CS_LOADER_VERIFY_EN to add a read-back verification pass before cs_ready.
module cs_loader #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 64,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  reload,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [ADDR_WIDTH-1:0] cs_addr_init,
  output logic [DATA_WIDTH-1:0] cs_data_in,
  output logic                  cs_ram__w,
  output logic                  cs_ready,
`ifdef CS_LOADER_VERIFY_EN
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  verify_err,
  output logic [ADDR_WIDTH-1:0] err_addr,
`endif
  output logic                  loading
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WRITE,
    HOLD,
`ifdef CS_LOADER_VERIFY_EN
    VERIFY,
`endif
    DONE
  } state_t;

  localparam logic [3:0]            LAT_LAST = 4'(ROM_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t     state;
  logic [3:0] lat_cnt;

  // Every output is a flop, so cs_ram__w cannot glitch and drops to 1 on async reset.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state        <= IDLE;
      cs_addr_init <= '0;
      cs_data_in   <= '0;
      cs_ram__w    <= 1'b1;
      cs_ready     <= 1'b0;
      loading      <= 1'b0;
      lat_cnt      <= '0;
`ifdef CS_LOADER_VERIFY_EN
      verify_err   <= 1'b0;
      err_addr     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          loading <= 1'b1;
          state   <= FETCH;
        end

        FETCH: begin
          if (lat_cnt == LAT_LAST) begin
            cs_data_in <= rom_data;
            lat_cnt    <= '0;
            cs_ram__w  <= 1'b0;
            state      <= WRITE;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end

        WRITE: begin
          cs_ram__w <= 1'b1;
          state     <= HOLD;
        end

        // Top-address test precedes the increment, so the counter never wraps mid-load.
        HOLD: begin
          if (cs_addr_init == TOP_ADDR) begin
            cs_addr_init <= '0;
`ifdef CS_LOADER_VERIFY_EN
            state        <= VERIFY;
`else
            cs_ready     <= 1'b1;
            loading      <= 1'b0;
            state        <= DONE;
`endif
          end else begin
            cs_addr_init <= cs_addr_init + ADDR_ONE;
            state        <= FETCH;
          end
        end

`ifdef CS_LOADER_VERIFY_EN
        // Only the first mismatching address is kept; later ones only keep the flag set.
        VERIFY: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt <= '0;
            if ((ram_rdata != rom_data) && !verify_err) begin
              verify_err <= 1'b1;
              err_addr   <= cs_addr_init;
            end
            if (cs_addr_init == TOP_ADDR) begin
              cs_addr_init <= '0;
              cs_ready     <= 1'b1;
              loading      <= 1'b0;
              state        <= DONE;
            end else begin
              cs_addr_init <= cs_addr_init + ADDR_ONE;
            end
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
`endif

        DONE: begin
          if (reload) begin
            cs_ready     <= 1'b0;
            cs_addr_init <= '0;
            loading      <= 1'b1;
            state        <= FETCH;
`ifdef CS_LOADER_VERIFY_EN
            verify_err   <= 1'b0;
            err_addr     <= '0;
`endif
          end
        end

        default: begin
          cs_ram__w <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cs_loader.sv
`timescale 1ns/1ps
// Bench for cs_loader: two instances (ROM_LATENCY 1 and 3) with EPROM/RAM models,
// table-driven timing checks plus reload and mid-load reset sequences.
module tb_cs_loader;

`ifdef CS_LOADER_VERIFY_EN
  localparam int DONE1 = 1 + 256 * 4;
  localparam int DONE3 = 1 + 256 * 8;
`else
  localparam int DONE1 = 1 + 256 * 3;
  localparam int DONE3 = 1 + 256 * 5;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rom_word(input logic [7:0] a);
    return {8{a}};
  endfunction

  logic        rst1_n = 1'b0, rst3_n = 1'b0, reload1 = 1'b0, reload3 = 1'b0;
  logic [63:0] rom1, rom3, din1, din3;
  logic [7:0]  addr1, addr3;
  logic        w1, w3, rdy1, rdy3, ld1, ld3;

  assign rom1 = rom_word(addr1);
  logic [7:0] d3a = 8'h0, d3b = 8'h0;
  always @(posedge clk) begin
    d3a <= addr3;
    d3b <= d3a;
  end
  assign rom3 = rom_word(d3b);

`ifdef CS_LOADER_VERIFY_EN
  logic [63:0] ram1 [256];
  logic [63:0] ram3 [256];
  logic [63:0] ram_rd1, ram_rd3;
  logic        verr1, verr3, ev3 = 1'b0, corrupt = 1'b1;
  logic [7:0]  eaddr1, eaddr3;
  always @(posedge clk) begin
    if (!w1) ram1[addr1] <= din1;
    if (!w3) ram3[addr3] <= din3;
  end
  assign ram_rd1 = ram1[addr1] ^ ((corrupt && (addr1 == 8'hA5 || addr1 == 8'hB0)) ? 64'h1 : 64'h0);
  assign ram_rd3 = ram3[addr3];
  always @(negedge clk) if (verr3) ev3 = 1'b1;
`endif

  cs_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(64), .ROM_LATENCY(1)) dut1 (
    .clk(clk), ._reset(rst1_n), .reload(reload1), .rom_data(rom1),
    .cs_addr_init(addr1), .cs_data_in(din1), .cs_ram__w(w1), .cs_ready(rdy1),
`ifdef CS_LOADER_VERIFY_EN
    .ram_rdata(ram_rd1), .verify_err(verr1), .err_addr(eaddr1),
`endif
    .loading(ld1)
  );

  cs_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(64), .ROM_LATENCY(3)) dut3 (
    .clk(clk), ._reset(rst3_n), .reload(reload3), .rom_data(rom3),
    .cs_addr_init(addr3), .cs_data_in(din3), .cs_ram__w(w3), .cs_ready(rdy3),
`ifdef CS_LOADER_VERIFY_EN
    .ram_rdata(ram_rd3), .verify_err(verr3), .err_addr(eaddr3),
`endif
    .loading(ld3)
  );

  // Edge counters: value after the n-th rising edge since reset release is n.
  int c1 = 0, c3 = 0;
  always @(posedge clk) begin
    c1 <= rst1_n ? c1 + 1 : 0;
    c3 <= rst3_n ? c3 + 1 : 0;
  end

  // Write monitors: order/data, pulse width, address hold time, cs_ready rise cycle.
  int wr1 = 0, bo1 = 0, bw1 = 0, rise1 = 0;
  int wr3 = 0, bo3 = 0, bw3 = 0, bh3 = 0, run3 = 0, rise3 = 0;
  logic low1 = 1'b0, seen1 = 1'b0, low3 = 1'b0, seen3 = 1'b0;
  logic [7:0] prev3 = 8'h0;
  always @(negedge clk) begin
    if (!rst1_n) begin
      wr1 = 0; bo1 = 0; bw1 = 0; low1 = 1'b0; seen1 = 1'b0; rise1 = 0;
    end else begin
      if (!w1) begin
        if (low1) bw1++;
        if (addr1 != 8'(wr1) || din1 != rom_word(addr1)) bo1++;
        wr1++;
      end
      low1 = !w1;
      if (rdy1 && !seen1) begin seen1 = 1'b1; rise1 = c1; end
    end
  end
  always @(negedge clk) begin
    if (!rst3_n) begin
      wr3 = 0; bo3 = 0; bw3 = 0; bh3 = 0; run3 = 0; prev3 = 8'h0;
      low3 = 1'b0; seen3 = 1'b0; rise3 = 0;
    end else begin
      run3 = (addr3 == prev3) ? run3 + 1 : 1;
      prev3 = addr3;
      if (!w3) begin
        if (low3) bw3++;
        if (run3 < 4) bh3++;
        if (addr3 != 8'(wr3) || din3 != rom_word(addr3)) bo3++;
        wr3++;
      end
      low3 = !w3;
      if (rdy3 && !seen3) begin seen3 = 1'b1; rise3 = c3; end
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          n;
    logic        rdy;
    logic        ld;
    logic        w;
    logic [7:0]  a;
    logic [63:0] d;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int cur;
    tbl[0]  = '{1,         1'b0, 1'b1, 1'b1, 8'h00, 64'h0};
    tbl[1]  = '{2,         1'b0, 1'b1, 1'b0, 8'h00, 64'h0};
    tbl[2]  = '{3,         1'b0, 1'b1, 1'b1, 8'h00, 64'h0};
    tbl[3]  = '{4,         1'b0, 1'b1, 1'b1, 8'h01, 64'h0};
    tbl[4]  = '{5,         1'b0, 1'b1, 1'b0, 8'h01, rom_word(8'h01)};
    tbl[5]  = '{6,         1'b0, 1'b1, 1'b1, 8'h01, rom_word(8'h01)};
    tbl[6]  = '{7,         1'b0, 1'b1, 1'b1, 8'h02, rom_word(8'h01)};
    tbl[7]  = '{302,       1'b0, 1'b1, 1'b0, 8'h64, rom_word(8'h64)};
    tbl[8]  = '{767,       1'b0, 1'b1, 1'b0, 8'hFF, rom_word(8'hFF)};
    tbl[9]  = '{DONE1 - 1, 1'b0, 1'b1, 1'b1, 8'hFF, rom_word(8'hFF)};
    tbl[10] = '{DONE1,     1'b1, 1'b0, 1'b1, 8'h00, rom_word(8'hFF)};
    tbl[11] = '{DONE1 + 10, 1'b1, 1'b0, 1'b1, 8'h00, rom_word(8'hFF)};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rdy1", 64'(rdy1), 64'(1'b0));
    chk("rst.ld1", 64'(ld1), 64'(1'b0));
    chk("rst.w1", 64'(w1), 64'(1'b1));
    chk("rst.addr1", 64'(addr1), 64'h0);
    chk("rst.din1", din1, 64'h0);
    chk("rst.w3", 64'(w3), 64'(1'b1));
`ifdef CS_LOADER_VERIFY_EN
    chk("rst.verr1", 64'(verr1), 64'(1'b0));
    chk("rst.eaddr1", 64'(eaddr1), 64'h0);
`endif
    #1;
    rst1_n = 1'b1;
    rst3_n = 1'b1;

    // First load, cycle-exact timing table on the latency-1 instance
    cur = 0;
    for (int i = 0; i < 12; i++) begin
      repeat (tbl[i].n - cur) @(posedge clk);
      cur = tbl[i].n;
      #1;
      chk($sformatf("t%0d.rdy", i), 64'(rdy1), 64'(tbl[i].rdy));
      chk($sformatf("t%0d.loading", i), 64'(ld1), 64'(tbl[i].ld));
      chk($sformatf("t%0d.wr_n", i), 64'(w1), 64'(tbl[i].w));
      chk($sformatf("t%0d.addr", i), 64'(addr1), 64'(tbl[i].a));
      chk($sformatf("t%0d.data", i), din1, tbl[i].d);
    end

    for (int i = 0; i < 3000 && !rdy3; i++) @(posedge clk);
    @(negedge clk);
    #1;
    chk("l1.writes", 64'(wr1), 64'd256);
    chk("l1.order", 64'(bo1), 64'd0);
    chk("l1.width", 64'(bw1), 64'd0);
    chk("l1.rise", 64'(rise1), 64'(DONE1));
    chk("l3.ready", 64'(rdy3), 64'(1'b1));
    chk("l3.writes", 64'(wr3), 64'd256);
    chk("l3.order", 64'(bo3), 64'd0);
    chk("l3.width", 64'(bw3), 64'd0);
    chk("l3.hold", 64'(bh3), 64'd0);
    chk("l3.rise", 64'(rise3), 64'(DONE3));
`ifdef CS_LOADER_VERIFY_EN
    chk("v1.err", 64'(verr1), 64'(1'b1));
    chk("v1.eaddr", 64'(eaddr1), 64'hA5);
    chk("v3.err_seen", 64'(ev3), 64'(1'b0));
    chk("v3.eaddr", 64'(eaddr3), 64'h0);
    corrupt = 1'b0;
`endif

    // Reload in DONE, then a reload mid-copy that must be ignored
    @(posedge clk);
    #2 reload1 = 1'b1;
    @(posedge clk);
    #1;
    chk("rl.rdy", 64'(rdy1), 64'(1'b0));
    chk("rl.addr", 64'(addr1), 64'h0);
    chk("rl.loading", 64'(ld1), 64'(1'b1));
`ifdef CS_LOADER_VERIFY_EN
    chk("rl.verr", 64'(verr1), 64'(1'b0));
    chk("rl.eaddr", 64'(eaddr1), 64'h0);
`endif
    #1 reload1 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (addr1 == 8'h10) break;
    end
    chk("rl.reach10", 64'(addr1), 64'h10);
    @(posedge clk);
    #2 reload1 = 1'b1;
    @(posedge clk);
    #2 reload1 = 1'b0;
    for (int i = 0; i < 3000 && !rdy1; i++) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rl2.ready", 64'(rdy1), 64'(1'b1));
    chk("rl2.writes", 64'(wr1), 64'd512);
    chk("rl2.order", 64'(bo1), 64'd0);
    chk("rl2.width", 64'(bw1), 64'd0);
`ifdef CS_LOADER_VERIFY_EN
    chk("rl2.verr", 64'(verr1), 64'(1'b0));
`endif

    // Asynchronous reset while DONE drops cs_ready without a clock edge
    @(posedge clk);
    #2 rst1_n = 1'b0;
    #1;
    chk("ar.rdy", 64'(rdy1), 64'(1'b0));
    repeat (2) @(posedge clk);
    #2 rst1_n = 1'b1;

    // Reset during the write pulse of word 0x40, then a full restart
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (addr1 == 8'h40 && !w1) break;
    end
    chk("mr.at40", 64'({addr1, w1}), 64'({8'h40, 1'b0}));
    #1 rst1_n = 1'b0;
    #1;
    chk("mr.w", 64'(w1), 64'(1'b1));
    chk("mr.rdy", 64'(rdy1), 64'(1'b0));
    chk("mr.addr", 64'(addr1), 64'h0);
    repeat (3) @(posedge clk);
    #2 rst1_n = 1'b1;
    for (int i = 0; i < 3000 && !rdy1; i++) @(posedge clk);
    @(negedge clk);
    #1;
    chk("mr.ready", 64'(rdy1), 64'(1'b1));
    chk("mr.writes", 64'(wr1), 64'd256);
    chk("mr.order", 64'(bo1), 64'd0);
    chk("mr.width", 64'(bw1), 64'd0);
    chk("mr.rise", 64'(rise1), 64'(DONE1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cs_loader.md
Name: cs_loader

Overview:
- Startup control-store loader, directly upstream of the microcode RAM control store.
- Sequences the microcode EPROM address, captures each ROM word, and strobes it into the control-store RAM with a clean active-low write pulse.
- Asserts cs_ready once the whole store is loaded. cs_ready then switches the CS address mux and CS clock selector to runtime mode.
- Replaces the ad-hoc counter, JK flip-flop and behavioural copier with one synchronous FSM.

Parameters:
- ADDR_WIDTH, 8, control-store address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 64, microinstruction width.
- ROM_LATENCY, 1, clk cycles from a cs_addr_init change to valid rom_data; legal range 1..15.

Ports:
- clk  in  1  system clock (clk_main domain).
- _reset  in  1  asynchronous, active-low reset.
- reload  in  1  synchronous request to re-copy the control store; sampled only in DONE.
- rom_data  in  DATA_WIDTH  microcode EPROM output.
- cs_addr_init  out  ADDR_WIDTH  address driven to the EPROM and the control-store RAM during load.
- cs_data_in  out  DATA_WIDTH  registered word presented to the RAM data input.
- cs_ram__w  out  1  RAM write strobe, active low.
- cs_ready  out  1  high when the control store is fully loaded.
- loading  out  1  high while the FSM is in FETCH, WRITE or HOLD (or VERIFY when compiled in).
- ram_rdata  in  DATA_WIDTH  RAM read-back data; present only with CS_LOADER_VERIFY_EN.
- verify_err  out  1  sticky mismatch flag; present only with CS_LOADER_VERIFY_EN.
- err_addr  out  ADDR_WIDTH  address of the first mismatch; present only with CS_LOADER_VERIFY_EN.

Behaviour:
- Reset (_reset low, asynchronous), all outputs and state:
  - state=IDLE, cs_addr_init=0, cs_data_in=0, cs_ram__w=1, cs_ready=0, loading=0, latency counter=0.
  - verify_err=0, err_addr=0.
- States: IDLE, FETCH, WRITE, HOLD, (VERIFY), DONE.
- IDLE: one cycle, then FETCH. Reset deassertion therefore always starts a fresh load.
- FETCH: holds cs_addr_init for ROM_LATENCY cycles.
  - On the last FETCH cycle, registers rom_data into cs_data_in.
  - Next state WRITE.
- WRITE: cs_ram__w=0 for exactly one cycle. Address and data are stable for the whole cycle. Next state HOLD.
- HOLD: cs_ram__w=1, address and data held (hold margin for the asynchronous RAM).
  - If cs_addr_init is the top address (all ones): go to DONE, or to VERIFY when compiled in.
  - Otherwise: increment cs_addr_init and go to FETCH.
- Throughput: ROM_LATENCY+2 cycles per word.
  - Total from reset release to cs_ready high = 1 + 2**ADDR_WIDTH*(ROM_LATENCY+2) cycles.
  - Default: 769 cycles.
- The address counter never wraps inside a load; the top-address test happens before increment.
- DONE:
  - cs_ready=1, loading=0, cs_ram__w=1.
  - cs_addr_init returns to 0 on entry and stays 0.
- reload high in DONE:
  - Next cycle cs_ready=0, cs_addr_init=0, state=FETCH.
  - reload in any other state is ignored, so a load is never restarted mid-copy.
- Reset mid-load: the asynchronous clear drops cs_ram__w to 1 immediately. No partial write pulse may outlive reset. The copy restarts from address 0.
- cs_ram__w is driven straight from a flop. It must be glitch-free and never low outside WRITE.
- cs_ready is registered and changes only on a clk rising edge, except for the asynchronous clear.

Optional Feature:
- Macro: CS_LOADER_VERIFY_EN.
- Defined:
  - After the last HOLD, enter VERIFY with cs_addr_init=0.
  - For each address, wait ROM_LATENCY cycles, then compare ram_rdata with rom_data.
  - On the first mismatch, set verify_err and capture the address into err_addr. Later mismatches do not overwrite err_addr.
  - After the top address, go to DONE. cs_ready asserts even on error; halting on error is the sequencer's job.
  - Adds 2**ADDR_WIDTH*ROM_LATENCY cycles.
  - reload clears verify_err and err_addr.
- Not defined:
  - VERIFY state, ram_rdata, verify_err and err_addr are absent.
  - HOLD at the top address goes straight to DONE.

Test Plan:
- ROM word(n) = {8{n[7:0]}}, ROM_LATENCY=1, release reset -> exactly 256 low pulses on cs_ram__w, each 1 cycle wide. Pulse k carries address k and data {8{k}}. cs_ready rises at cycle 769.
- ROM_LATENCY=3 -> address held 3 cycles before each write pulse; cs_ready rises at cycle 1+256*5=1281.
- Assert _reset low at word 0x40 during WRITE -> cs_ram__w=1 and cs_ready=0 immediately. After release, writes restart at address 0x00 and complete 256 words.
- reload pulsed mid-load (address 0x10) -> ignored, load completes normally. reload pulsed in DONE -> cs_ready falls next cycle and a full second copy occurs.
- VERIFY_EN, RAM model corrupts address 0xA5 and 0xB0 -> verify_err=1, err_addr=0xA5, cs_ready=1 after 256*4+1 cycles.
- VERIFY_EN, clean RAM -> verify_err stays 0 throughout; reload returns verify_err/err_addr to 0.
